// File: rtl/md_unit_iter.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one step per cycle, followed by a sign-fix cycle that writes HI/LO.
//
// Handshake: an op is taken only when en = 1, req = 0 and the unit is idle
// (busy = 0). Anything presented while busy or while req = 1 is dropped;
// there is no ready/back-pressure, the pipeline must stall on busy itself.
module md_unit_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req,
  input  logic [3:0]       MDop,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_opnd;     // multiplicand magnitude, or divisor magnitude
  logic [2*WIDTH-1:0] r_prod;     // {acc, multiplier} or {remainder, quotient}
  logic               r_neg_res;  // product / quotient must be negated
  logic               r_neg_rem;  // remainder must be negated
  logic               r_bzero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  // Issue decode
  logic               w_accept;
  logic               w_compute;
  logic               w_signed;
  logic               w_div_issue;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  assign w_accept    = (r_state == S_IDLE) && en && !req;
  assign w_compute   = ((MDop >= OP_MULT) && (MDop <= OP_DIVU)) ||
                       ((MDop >= OP_MADD) && (MDop <= OP_MSUBU));
  assign w_signed    = (MDop == OP_MULT) || (MDop == OP_DIV) ||
                       (MDop == OP_MADD) || (MDop == OP_MSUB);
  assign w_div_issue = (MDop == OP_DIV) || (MDop == OP_DIVU);
  assign w_a_neg     = w_signed && A[WIDTH-1];
  assign w_b_neg     = w_signed && B[WIDTH-1];
  assign w_mag_a     = w_a_neg ? -A : A;
  assign w_mag_b     = w_b_neg ? -B : B;

  // Iteration step datapath
  logic               w_is_div;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_is_div   = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                      {1'b0, (r_prod[0] ? r_opnd : '0)};
  assign w_mul_next = {w_sum, r_prod[WIDTH-1:1]};
  // Shift the next dividend bit into the remainder and try subtracting.
  assign w_trial    = r_prod[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_next = w_trial[WIDTH]
                    ? {r_prod[2*WIDTH-2:0], 1'b0}
                    : {w_trial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_hilo;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod_s = r_neg_res ? -r_prod : r_prod;
  assign w_hilo   = {r_hi, r_lo};
  assign w_quot   = r_neg_res ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_rem    = r_neg_rem ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_compute) w_next = S_RUN;
      S_RUN:   if (r_cnt == CW'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration steps and HI/LO write-back
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_op      <= '0;
      r_opnd    <= '0;
      r_prod    <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_bzero   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_compute) begin
              r_op      <= MDop;
              r_cnt     <= CW'(WIDTH);
              r_opnd    <= w_div_issue ? w_mag_b : w_mag_a;
              r_prod    <= {{WIDTH{1'b0}}, (w_div_issue ? w_mag_a : w_mag_b)};
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
              r_bzero   <= (B == '0);
            end else if (MDop == OP_MTHI) begin
              r_hi <= A;
            end else if (MDop == OP_MTLO) begin
              r_lo <= A;
            end
          end
        end
        S_RUN: begin
          r_cnt  <= r_cnt - CW'(1);
          r_prod <= w_is_div ? w_div_next : w_mul_next;
        end
        S_FIX: begin
          case (r_op)
            OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod_s;
            OP_MADD, OP_MADDU: {r_hi, r_lo} <= w_hilo + w_prod_s;
            OP_MSUB, OP_MSUBU: {r_hi, r_lo} <= w_hilo - w_prod_s;
            OP_DIV, OP_DIVU: begin
              if (!r_bzero) begin
                r_lo <= w_quot;
                r_hi <= w_rem;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Read port and status outputs
  always_comb begin
    out = '0;
    if (MDop == OP_MFHI)      out = r_hi;
    else if (MDop == OP_MFLO) out = r_lo;
  end

  assign HI          = r_hi;
  assign LO          = r_lo;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule
